// File: rtl/param_dispatcher.sv
// NoC traffic dispatcher: packs IN_DW words into NOC_DW flits, queues them in a sync-read RAM and
// presents them as fixed-length AXI-Stream packets with round-robin destinations.
module param_dispatcher #(
    parameter int                 NOC_DW    = 512,
    parameter int                 IN_DW     = 64,
    parameter int                 BYTE_DW   = 8,
    parameter int                 USER_DW   = 32,
    parameter int                 DEPTH     = 16,
    parameter int                 PKT_LEN   = 4,
    parameter int                 NUM_DEST  = 3,
    parameter logic [BYTE_DW-1:0] DEST_BASE = 8'h10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_DW-1:0]          ififo_wdata,
    input  logic                      ififo_wen,
    output logic                      ififo_rdy,
    output logic                      tx_tvalid,
    output logic [NOC_DW-1:0]         tx_tdata,
    output logic [NOC_DW/8-1:0]       tx_tstrb,
    output logic [NOC_DW/8-1:0]       tx_tkeep,
    output logic [BYTE_DW-1:0]        tx_tid,
    output logic [BYTE_DW-1:0]        tx_tdest,
    output logic [USER_DW-1:0]        tx_tuser,
    output logic                      tx_tlast,
    input  logic                      tx_tready,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PACK   = NOC_DW / IN_DW;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int DIDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);
    localparam logic [DIDX_W-1:0] DIDX_LAST = DIDX_W'(NUM_DEST - 1);

    if (NOC_DW % IN_DW != 0) begin : g_bad_pack
        $error("NOC_DW must be a multiple of IN_DW");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if ((NUM_DEST < 1) || (NUM_DEST > 256) || (PKT_LEN < 1)) begin : g_bad_frame
        $error("PKT_LEN must be >= 1 and NUM_DEST in 1..256");
    end

    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
        return (lane == LANE_LAST) ? '0 : lane + LANE_W'(1);
    endfunction

    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] beat);
        return (beat == BEAT_LAST) ? '0 : beat + BEAT_W'(1);
    endfunction

    function automatic logic [DIDX_W-1:0] next_didx(input logic [DIDX_W-1:0] idx);
        return (idx == DIDX_LAST) ? '0 : idx + DIDX_W'(1);
    endfunction

    // Destination IDs wrap modulo 2^BYTE_DW.
    function automatic logic [BYTE_DW-1:0] dest_id(input logic [DIDX_W-1:0] idx);
        return DEST_BASE + BYTE_DW'(idx);
    endfunction

    logic                    live;
    logic [LANE_W-1:0]       lane_p0;
    logic [NOC_DW-1:0]       pack_p0;
    logic [NOC_DW-1:0]       flit_p0;
    logic                    accept;
    logic                    push;

    logic [NOC_DW-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        st_cnt;
    logic                    issue;
    logic [NOC_DW-1:0]       ram_q_p1;
    logic                    vld_p1;

    logic                    load_p2;
    logic                    hs;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [BYTE_DW-1:0]      tid_cnt;
    logic [DIDX_W-1:0]       didx_cnt;

    // ---- stage p0: word packing ----
    // The last lane may only be taken when there is room for the flit it completes.
    assign ififo_rdy = live && ((occupancy < OCC_FULL) || (lane_p0 != LANE_LAST));
    assign accept    = ififo_wen && ififo_rdy;
    assign push      = accept && (lane_p0 == LANE_LAST);

    always_comb begin
        flit_p0 = pack_p0;
        flit_p0[int'(lane_p0) * IN_DW +: IN_DW] = ififo_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= 1'b0;
            lane_p0  <= '0;
            pack_p0  <= '0;
            overflow <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                lane_p0 <= next_lane(lane_p0);
                pack_p0 <= flit_p0;
            end
            if (ififo_wen && !ififo_rdy) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---- stage p1: flit storage and synchronous read ----
    // A read is launched whenever the read register is free or is being drained this cycle.
    assign hs      = tx_tvalid && tx_tready;
    assign load_p2 = vld_p1 && (!tx_tvalid || hs);
    assign issue   = (st_cnt != '0) && (!vld_p1 || load_p2);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_p0;
        end
        if (issue) begin
            ram_q_p1 <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            st_cnt    <= '0;
            vld_p1    <= 1'b0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   st_cnt <= st_cnt + OCC_W'(1);
                2'b01:   st_cnt <= st_cnt - OCC_W'(1);
                default: st_cnt <= st_cnt;
            endcase
            if (issue) begin
                vld_p1 <= 1'b1;
            end else if (load_p2) begin
                vld_p1 <= 1'b0;
            end
            case ({push, hs})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // ---- stage p2: AXI-Stream output register with framing ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
            tx_tid    <= '0;
            tx_tdest  <= '0;
            tx_tuser  <= '0;
            tx_tlast  <= 1'b0;
            beat_cnt  <= '0;
            tid_cnt   <= '0;
            didx_cnt  <= '0;
        end else if (load_p2) begin
            tx_tvalid <= 1'b1;
            tx_tdata  <= ram_q_p1;
            tx_tid    <= tid_cnt;
            tx_tdest  <= dest_id(didx_cnt);
            tx_tuser  <= USER_DW'(beat_cnt);
            tx_tlast  <= (beat_cnt == BEAT_LAST);
            beat_cnt  <= next_beat(beat_cnt);
            if (beat_cnt == BEAT_LAST) begin
                tid_cnt  <= tid_cnt + BYTE_DW'(1);
                didx_cnt <= next_didx(didx_cnt);
            end
        end else if (hs) begin
            tx_tvalid <= 1'b0;
        end
    end

    assign tx_tstrb = {(NOC_DW/8){tx_tvalid}};
    assign tx_tkeep = {(NOC_DW/8){tx_tvalid}};

endmodule
